// File: rtl/turn_stalk_pkg.sv
// Shared types and defaults for the turn-stalk input stage.
package turn_stalk_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_LEFT  = 2'b01,
        S_RIGHT = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    localparam int DB_CYCLES_DEF = 4;

endpackage

// File: rtl/stalk_debounce.sv
// Two-flop synchroniser followed by a consecutive-edge debounce counter.
module stalk_debounce
    import turn_stalk_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // The counter tops out at DB_CYCLES-1: the next differing edge flips the stable value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/turn_stalk_ctrl.sv
// Turn-stalk input stage: debounced stalk/hazard inputs, direction FSM and hazard latch.
//
// state   | meaning
// S_OFF   | no stalk contact made
// S_LEFT  | left contact only, TL asserted
// S_RIGHT | right contact only, TR asserted
// S_FAULT | both contacts seen, held until both release
module turn_stalk_ctrl
    import turn_stalk_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic stalk_l_raw,
    input  logic stalk_r_raw,
    input  logic haz_btn_raw,
    output logic TL,
    output logic TR,
    output logic E,
    output logic fault
);

    localparam logic [CNT_W:0] WARM_LAST = (CNT_W + 1)'(DB_CYCLES + 2);

    logic           w_l_db;
    logic           w_r_db;
    logic           w_btn_db;
    logic           w_toggle;
    state_t         r_state;
    state_t         w_next;
    logic           r_tl;
    logic           r_tr;
    logic           r_fault;
    logic           r_haz;
    logic           r_btn_prev;
    logic           r_armed;
    logic [CNT_W:0] r_warm;

    stalk_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_l (
        .clk(clk), .rst(rst), .i_raw(stalk_l_raw), .o_stable(w_l_db)
    );

    stalk_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_r (
        .clk(clk), .rst(rst), .i_raw(stalk_r_raw), .o_stable(w_r_db)
    );

    stalk_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_btn (
        .clk(clk), .rst(rst), .i_raw(haz_btn_raw), .o_stable(w_btn_db)
    );

    // A button held through reset debounces high within the warm-up window; it only
    // arms once it has been seen released, so that press cannot toggle the latch.
    assign w_toggle = r_armed & w_btn_db & ~r_btn_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_OFF;
            r_tl       <= 1'b0;
            r_tr       <= 1'b0;
            r_fault    <= 1'b0;
            r_haz      <= 1'b0;
            r_btn_prev <= 1'b0;
            r_armed    <= 1'b0;
            r_warm     <= '0;
        end else begin
            r_state    <= w_next;
            r_tl       <= (w_next == S_LEFT);
            r_tr       <= (w_next == S_RIGHT);
            r_fault    <= (w_next == S_FAULT);
            r_btn_prev <= w_btn_db;
            if (w_toggle) begin
                r_haz <= ~r_haz;
            end
            if (r_warm != WARM_LAST) begin
                r_warm <= r_warm + (CNT_W + 1)'(1);
            end else if (!w_btn_db) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OFF: begin
                if (w_l_db && w_r_db)      w_next = S_FAULT;
                else if (w_l_db)           w_next = S_LEFT;
                else if (w_r_db)           w_next = S_RIGHT;
            end
            S_LEFT: begin
                if (w_r_db)                w_next = S_FAULT;
                else if (!w_l_db)          w_next = S_OFF;
            end
            S_RIGHT: begin
                if (w_l_db)                w_next = S_FAULT;
                else if (!w_r_db)          w_next = S_OFF;
            end
            S_FAULT: begin
                if (!w_l_db && !w_r_db)    w_next = S_OFF;
            end
            default:                       w_next = S_OFF;
        endcase
    end

    assign TL    = r_tl;
    assign TR    = r_tr;
    assign E     = r_haz;
    assign fault = r_fault;

endmodule

// File: tb/tb_turn_stalk_ctrl.sv
// Directed bench for turn_stalk_ctrl; outputs sampled on the falling edge as {TL,TR,E,fault}.
`timescale 1ns/1ps
module tb_turn_stalk_ctrl;

    logic clk;
    logic rst;
    logic stalk_l_raw;
    logic stalk_r_raw;
    logic haz_btn_raw;
    logic TL;
    logic TR;
    logic E;
    logic fault;

    int n_cmp = 0;
    int n_mis = 0;

    turn_stalk_ctrl dut (
        .clk(clk),
        .rst(rst),
        .stalk_l_raw(stalk_l_raw),
        .stalk_r_raw(stalk_r_raw),
        .haz_btn_raw(haz_btn_raw),
        .TL(TL),
        .TR(TR),
        .E(E),
        .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_v);
        logic [3:0] obs_v;
        obs_v = {TL, TR, E, fault};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_mis++;
            $error("FAIL %s: {TL,TR,E,fault} observed %b expected %b", tag, obs_v, exp_v);
        end
    endtask

    initial begin
        rst         = 1'b1;
        stalk_l_raw = 1'b0;
        stalk_r_raw = 1'b0;
        haz_btn_raw = 1'b0;

        // reset
        #4 rst = 1'b0;
        #1 chk("reset_async", 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("reset_idle", 4'b0000);
        end

        // clean left press and release
        stalk_l_raw = 1'b1;
        edges(6); chk("left_edge6", 4'b0000);
        edges(1); chk("left_edge7", 4'b1000);
        stalk_l_raw = 1'b0;
        edges(6); chk("left_rel6", 4'b1000);
        edges(1); chk("left_rel7", 4'b0000);

        // bounce rejection on right contact
        for (int i = 0; i < 10; i++) begin
            stalk_r_raw = 1'b1;
            edges(3);
            chk("bounce_hi", 4'b0000);
            stalk_r_raw = 1'b0;
            edges(1);
            chk("bounce_lo", 4'b0000);
        end
        stalk_r_raw = 1'b1;
        edges(6); chk("right_edge6", 4'b0000);
        edges(1); chk("right_edge7", 4'b0100);
        stalk_r_raw = 1'b0;
        edges(8); chk("right_rel", 4'b0000);

        // conflict handling
        stalk_l_raw = 1'b1;
        edges(7); chk("conf_left", 4'b1000);
        stalk_r_raw = 1'b1;
        edges(6); chk("conf_both6", 4'b1000);
        edges(1); chk("conf_both7", 4'b0001);
        stalk_l_raw = 1'b0;
        edges(8); chk("conf_right_only", 4'b0001);
        stalk_r_raw = 1'b0;
        edges(6); chk("conf_clear6", 4'b0001);
        edges(1); chk("conf_clear7", 4'b0000);

        // hazard toggle
        haz_btn_raw = 1'b1;
        edges(6); chk("haz_on6", 4'b0000);
        edges(1); chk("haz_on7", 4'b0010);
        edges(13); chk("haz_held", 4'b0010);
        haz_btn_raw = 1'b0;
        edges(8); chk("haz_release", 4'b0010);
        haz_btn_raw = 1'b1;
        edges(6); chk("haz_off6", 4'b0010);
        edges(1); chk("haz_off7", 4'b0000);
        haz_btn_raw = 1'b0;
        edges(8); chk("haz_off_rel", 4'b0000);

        // hazard together with left turn
        stalk_l_raw = 1'b1;
        edges(7); chk("combo_left", 4'b1000);
        haz_btn_raw = 1'b1;
        edges(7); chk("combo_haz", 4'b1010);
        haz_btn_raw = 1'b0;
        edges(8); chk("combo_rel", 4'b1010);

        // reset mid-operation, button held through reset
        stalk_r_raw = 1'b1;
        haz_btn_raw = 1'b1;
        edges(3);
        rst = 1'b0;
        #1 chk("midop_reset", 4'b0000);
        stalk_l_raw = 1'b0;
        stalk_r_raw = 1'b0;
        edges(2);
        rst = 1'b1;
        edges(7); chk("held_btn7", 4'b0000);
        edges(13); chk("held_btn20", 4'b0000);
        haz_btn_raw = 1'b0;
        edges(8); chk("held_release", 4'b0000);
        haz_btn_raw = 1'b1;
        edges(6); chk("repress6", 4'b0000);
        edges(1); chk("repress7", 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
